// File: rtl/cim_weight_loader.sv
// Write-port driver for cim_bank: pairs 12-bit beats into row words and
// strobes one-hot row write enables across a programmable row window.
module cim_weight_loader #(
    parameter int N_ROWS = 8,
    parameter int DW     = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          row_base,
    input  logic [3:0]          row_cnt,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_data,
    output logic [2*DW-1:0]     D,
    output logic [N_ROWS-1:0]   WA,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [4:0]        N_ROWS_W = 5'(N_ROWS);
    localparam logic [N_ROWS-1:0] WA_ONE   = N_ROWS'(1);

    state_t         state_r;
    logic [2:0]     row_r;
    logic [3:0]     rem_r;
    logic [DW-1:0]  a_r;
    logic [4:0]     row_end_s;
    logic           cmd_bad_s;

    // Window legality of the start command, evaluated in 5 bits so base+cnt cannot wrap
    always_comb begin
        row_end_s = {2'b00, row_base} + {1'b0, row_cnt};
        cmd_bad_s = (row_cnt == 4'd0) || (row_end_s > N_ROWS_W);
    end

    // Control FSM with all outputs registered; strobes default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            row_r   <= 3'd0;
            rem_r   <= 4'd0;
            a_r     <= '0;
            D       <= '0;
            WA      <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            WA   <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                s_ready <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (cmd_bad_s) begin
                                err <= 1'b1;
                            end else begin
                                row_r   <= row_base;
                                rem_r   <= row_cnt;
                                state_r <= GET_A;
                                s_ready <= 1'b1;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    GET_A: begin
                        if (s_valid && s_ready) begin
                            a_r     <= s_data;
                            state_r <= GET_B;
                        end
                    end
                    GET_B: begin
                        // WA is launched together with D so both are valid in the WRITE cycle
                        if (s_valid && s_ready) begin
                            D       <= {a_r, s_data};
                            WA      <= WA_ONE << row_r;
                            s_ready <= 1'b0;
                            state_r <= WRITE;
                        end
                    end
                    WRITE: begin
                        row_r <= row_r + 3'd1;
                        rem_r <= rem_r - 4'd1;
                        if (rem_r == 4'd1) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= GET_A;
                            s_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
